// File: rtl/lcd_ctrl_if.sv
// LCD controller bus: LSU-side register word in, HD44780 pins and status word out.
interface lcd_ctrl_if;
    localparam int unsigned REG_W  = 32;
    localparam int unsigned DATA_W = 8;

    logic [REG_W-1:0]  i_lcd_reg;
    logic              o_lcd_on;
    logic              o_lcd_en;
    logic              o_lcd_rs;
    logic              o_lcd_rw;
    logic [DATA_W-1:0] o_lcd_data;
    logic [REG_W-1:0]  o_lcd_status;

    // LSU / firmware side
    modport master (
        output i_lcd_reg,
        input  o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_status
    );

    // Controller side
    modport slave (
        input  i_lcd_reg,
        output o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_status
    );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write sequencer: turns a toggle request in the LCD register
// into setup / EN pulse / hold / execution-wait bus cycles, with busy+ack readback.
module lcd_ctrl #(
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned PULSE_CYC     = 12,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned LONG_EXEC_CYC = 82000,
    parameter int unsigned CNT_W         = 17
) (
    input  logic     i_clk,
    input  logic     i_reset,
    lcd_ctrl_if.slave bus
);

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned STAT_PAD_W = 30;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_EXEC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               rs_q, rs_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               on_q, on_d;
    logic               long_c;
    logic               cnt_zero_c;
    logic               unused_reg_bits_c;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait; 0x00 rides along.
    assign long_c     = !rs_q && ((data_q[7:1] == 7'b0000000) || (data_q[7:1] == 7'b0000001));
    assign cnt_zero_c = (cnt_q == '0);

    // Register bits [30:10] carry nothing for this block.
    assign unused_reg_bits_c = ^bus.i_lcd_reg[30:10];

    // Next-state and next-output logic for the bus-cycle sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        busy_d  = busy_q;
        ack_d   = ack_q;
        on_d    = bus.i_lcd_reg[31];

        case (state_q)
            S_IDLE: begin
                if (bus.i_lcd_reg[9] != ack_q) begin
                    data_d  = bus.i_lcd_reg[7:0];
                    rs_d    = bus.i_lcd_reg[8];
                    busy_d  = 1'b1;
                    cnt_d   = SETUP_LOAD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_zero_c) begin
                    en_d    = 1'b1;
                    cnt_d   = PULSE_LOAD;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_zero_c) begin
                    en_d    = 1'b0;
                    cnt_d   = HOLD_LOAD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_zero_c) begin
                    cnt_d   = long_c ? LONG_LOAD : EXEC_LOAD;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_zero_c) begin
                    ack_d   = ~ack_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops EN and clears everything immediately.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            on_q    <= on_d;
        end
    end

    assign bus.o_lcd_on     = on_q;
    assign bus.o_lcd_en     = en_q;
    assign bus.o_lcd_rs     = rs_q;
    assign bus.o_lcd_rw     = 1'b0;
    assign bus.o_lcd_data   = data_q;
    assign bus.o_lcd_status = {STAT_PAD_W'(0), ack_q, busy_q};

endmodule
